// File: rtl/rs_encoder.sv
// Systematic RS(6,2) encoder over GF(2^8): LFSR parity division,
// parallel codeword on w1..w6 plus a serial symbol stream.
module rs_encoder #(
    parameter logic [8:0] GF_POLY = 9'h11D,
    parameter logic [7:0] G3      = 8'd15,
    parameter logic [7:0] G2      = 8'd54,
    parameter logic [7:0] G1      = 8'd120,
    parameter logic [7:0] G0      = 8'd64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal,
    input  logic [7:0] d1,
    input  logic [7:0] d0,
    output logic       busy,
    output logic       ready,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic       sym_valid,
    output logic [7:0] sym_out
);

    typedef enum logic [1:0] {IDLE, SHIFT1, SHIFT2, EMIT} state_t;

    state_t     state, state_n;
    logic [7:0] m1, m0;
    logic [7:0] r3, r2, r1, r0;
    logic [7:0] u, fb, n3, n2, n1, n0, sel;
    logic [2:0] cnt;
    logic       accept, step;

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

    // busy covers the trailing serial symbol after the FSM is back in IDLE
    assign busy   = (state != IDLE) || sym_valid;
    assign accept = signal && !busy;
    assign step   = (state == SHIFT1) || (state == SHIFT2);

    assign u  = (state == SHIFT1) ? m1 : m0;
    assign fb = u ^ r3;
    assign n3 = r2 ^ gf_mul(fb, G3);
    assign n2 = r1 ^ gf_mul(fb, G2);
    assign n1 = r0 ^ gf_mul(fb, G1);
    assign n0 = gf_mul(fb, G0);

    always_comb begin
        sel = '0;
        unique case (cnt)
            3'd0:    sel = w1;
            3'd1:    sel = w2;
            3'd2:    sel = w3;
            3'd3:    sel = w4;
            3'd4:    sel = w5;
            3'd5:    sel = w6;
            default: sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = SHIFT1;
            SHIFT1:  state_n = SHIFT2;
            SHIFT2:  state_n = EMIT;
            EMIT:    if (cnt == 3'd5) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= '0; m0 <= '0;
            r3 <= '0; r2 <= '0; r1 <= '0; r0 <= '0;
            w1 <= '0; w2 <= '0; w3 <= '0;
            w4 <= '0; w5 <= '0; w6 <= '0;
            cnt       <= '0;
            ready     <= 1'b0;
            sym_valid <= 1'b0;
            sym_out   <= '0;
        end else begin
            if (accept) begin
                m1 <= d1; m0 <= d0;
                r3 <= '0; r2 <= '0; r1 <= '0; r0 <= '0;
            end
            if (step) begin
                r3 <= n3; r2 <= n2; r1 <= n1; r0 <= n0;
            end
            if (state == SHIFT2) begin
                w1 <= m1; w2 <= m0;
                w3 <= n3; w4 <= n2; w5 <= n1; w6 <= n0;
            end
            // serial outputs are registered, so they trail the EMIT state by one cycle
            if (state == EMIT) begin
                cnt       <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
                ready     <= (cnt == 3'd0);
                sym_valid <= 1'b1;
                sym_out   <= sel;
            end else begin
                cnt       <= '0;
                ready     <= 1'b0;
                sym_valid <= 1'b0;
                sym_out   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: vector table, scoreboard with a log/antilog
// GF model, syndrome check, timing, busy, held-signal and reset cases.
module tb_rs_encoder;

    typedef logic [0:5][7:0] cw_t;
    typedef struct {
        cw_t c;
        int  acc;
    } sb_t;
    typedef struct {
        logic [7:0] d1;
        logic [7:0] d0;
        cw_t        w;
    } vec_t;

    logic       clk, rst_n, signal;
    logic [7:0] d1, d0;
    logic       busy, ready, sym_valid;
    logic [7:0] w1, w2, w3, w4, w5, w6, sym_out;
    cw_t        dutw;

    int   checks, passes, cyc, ready_cnt, ready_cyc_last;
    int   spos, bz_from, bz_to;
    int   e_tab [256];
    int   l_tab [256];
    int   gen   [4];
    cw_t  scur, last_w;
    sb_t  sb [$];
    vec_t vecs [4];

    rs_encoder dut (
        .clk(clk), .rst_n(rst_n), .signal(signal),
        .d1(d1), .d0(d0), .busy(busy), .ready(ready),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6),
        .sym_valid(sym_valid), .sym_out(sym_out)
    );

    assign dutw = {w1, w2, w3, w4, w5, w6};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        if (a == 0 || b == 0) return 8'd0;
        return 8'(e_tab[(l_tab[a] + l_tab[b]) % 255]);
    endfunction

    // long division of d1*x^5 + d0*x^4 by g(x)
    function automatic cw_t enc(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] m [6];
        logic [7:0] coef;
        cw_t        r;
        m = '{a, b, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 2; i++) begin
            coef = m[i];
            for (int j = 1; j <= 4; j++)
                m[i+j] ^= gmul(8'(gen[j-1]), coef);
        end
        m[0] = a;
        m[1] = b;
        for (int k = 0; k < 6; k++) r[k] = m[k];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic mon();
        sb_t        e;
        logic [7:0] s;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            spos    = -1;
            bz_from = -1;
            bz_to   = -2;
            return;
        end
        chk("busy", 48'(busy), 48'(cyc >= bz_from && cyc <= bz_to));
        if (signal && !busy) begin
            e.c   = enc(d1, d0);
            e.acc = cyc;
            sb.push_back(e);
            bz_from = cyc + 1;
            bz_to   = cyc + 9;
        end
        if (ready) begin
            ready_cnt++;
            ready_cyc_last = cyc;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL ready_spurious: got ready=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("ready_latency", 48'(cyc - e.acc), 48'd4);
                chk("codeword", dutw, e.c);
                for (int j = 0; j < 4; j++) begin
                    s = 8'd0;
                    for (int k = 0; k < 6; k++)
                        s = gmul(s, 8'(e_tab[j])) ^ dutw[k];
                    chk("syndrome", 48'(s), 48'd0);
                end
                scur   = e.c;
                spos   = 0;
                last_w = dutw;
            end
        end else if (sb.size() > 0 && cyc > sb[0].acc + 4) begin
            checks++;
            $display("FAIL ready_missing: got ready=0 expected 1 at cycle %0d", cyc);
            void'(sb.pop_front());
        end
        chk("sym_valid", 48'(sym_valid), 48'(spos >= 0));
        if (spos >= 0) begin
            chk("sym_out", 48'(sym_out), 48'(scur[spos]));
            spos++;
            if (spos == 6) spos = -1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b);
        int rc;
        rc = ready_cnt;
        signal = 1'b1;
        d1 = a;
        d0 = b;
        cycle();
        signal = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!busy && ready_cnt != rc) break;
            cycle();
        end
        chk("run_ready_count", 48'(ready_cnt - rc), 48'd1);
    endtask

    initial begin
        int  rc, r1, r2;
        cw_t ex;
        checks = 0; passes = 0; cyc = 0; ready_cnt = 0;
        ready_cyc_last = 0;
        spos = -1; bz_from = -1; bz_to = -2;
        e_tab[0] = 1;
        for (int i = 1; i < 256; i++) begin
            e_tab[i] = (e_tab[i-1] << 1) ^ ((e_tab[i-1] & 8'h80) != 0 ? 9'h11D : 0);
        end
        for (int i = 0; i < 256; i++) l_tab[i] = 0;
        for (int i = 0; i < 255; i++) l_tab[e_tab[i]] = i;
        gen[0] = 15; gen[1] = 54; gen[2] = 120; gen[3] = 64;

        vecs[0].d1 = 8'd0; vecs[0].d0 = 8'd1;
        vecs[0].w  = {8'd0, 8'd1, 8'd15, 8'd54, 8'd120, 8'd64};
        vecs[1].d1 = 8'd1; vecs[1].d0 = 8'd0;
        vecs[1].w  = {8'd1, 8'd0, 8'd99, 8'd87, 8'd210, 8'd231};
        vecs[2].d1 = 8'd1; vecs[2].d0 = 8'd1;
        vecs[2].w  = {8'd1, 8'd1, 8'd108, 8'd97, 8'd170, 8'd167};
        vecs[3].d1 = 8'd0; vecs[3].d0 = 8'd0;
        vecs[3].w  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        rst_n = 1'b0; signal = 1'b0; d1 = 8'd0; d0 = 8'd0;
        cycle();
        cycle();
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_ready", 48'(ready), 48'd0);
        chk("rst_sym_valid", 48'(sym_valid), 48'd0);
        chk("rst_sym_out", 48'(sym_out), 48'd0);
        chk("rst_w", dutw, 48'd0);
        rst_n = 1'b1;
        repeat (20) cycle();
        chk("no_ready_after_reset", 48'(ready_cnt), 48'd0);

        for (int i = 0; i < 4; i++) begin
            run_one(vecs[i].d1, vecs[i].d0);
            chk("vec_w", last_w, vecs[i].w);
            repeat (3) cycle();
            chk("vec_hold", dutw, vecs[i].w);
        end

        // extra starts while busy must be ignored
        rc = ready_cnt;
        signal = 1'b1; d1 = 8'h12; d0 = 8'h34;
        cycle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            signal = 1'b1; d1 = 8'd5; d0 = 8'd3;
            cycle();
        end
        signal = 1'b0;
        repeat (4) cycle();
        chk("pulse_ready_count", 48'(ready_cnt - rc), 48'd1);
        ex = enc(8'h12, 8'h34);
        chk("pulse_hold", dutw, ex);

        // held signal: back-to-back codewords
        rc = ready_cnt; r1 = -1; r2 = -1;
        signal = 1'b1; d1 = 8'd7; d0 = 8'd9;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (ready_cnt == rc + 1 && r1 < 0) begin
                r1 = ready_cyc_last;
                d1 = 8'hAB; d0 = 8'hCD;
            end
            if (ready_cnt == rc + 2) begin
                r2 = ready_cyc_last;
                break;
            end
        end
        signal = 1'b0;
        chk("b2b_spacing", 48'(r2 - r1), 48'd10);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cycle();
        end
        ex = enc(8'hAB, 8'hCD);
        chk("b2b_second_w", dutw, ex);

        // asynchronous reset in the middle of the serial stream
        signal = 1'b1; d1 = 8'h5A; d0 = 8'hC3;
        cycle();
        signal = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (spos == 3) break;
            cycle();
        end
        chk("mid_emit_reached", 48'(spos), 48'd3);
        rst_n = 1'b0;
        #1;
        chk("async_sym_valid", 48'(sym_valid), 48'd0);
        chk("async_busy", 48'(busy), 48'd0);
        chk("async_ready", 48'(ready), 48'd0);
        chk("async_w", dutw, 48'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("post_reset_no_ready", 48'(sym_valid | ready | busy), 48'd0);
        run_one(8'h5A, 8'hC3);
        ex = enc(8'h5A, 8'hC3);
        chk("post_reset_w", last_w, ex);

        for (int n = 0; n < 500; n++)
            run_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        repeat (3) cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
